// File: rtl/message_stream_splitter.sv
// message_stream_splitter
//   Splits one combined message stream into N_STREAMS output streams.
//   Each message is a header word followed by L payload words. The header
//   carries the flag bit (MSB = 1), a stream id and the payload length L.
//   The header and its payload are forwarded, one cycle later, on the shared
//   out_data bus. The out_nd bit of the selected stream is set with the word.
//   Malformed words seen while waiting for a header are dropped, and they set
//   a sticky error flag.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   in_data  : combined stream word (WIDTH bits)
//   in_nd    : in_data valid this cycle
//   out_data : word shared by all output streams (holds when out_nd == 0)
//   out_nd   : one-hot per-stream valid (N_STREAMS bits)
//   error    : sticky protocol-error flag, cleared only by reset
module message_stream_splitter #(
  parameter int N_STREAMS         = 2,
  parameter int LOG_N_STREAMS     = 1,
  parameter int WIDTH             = 32,
  parameter int MAX_PACKET_LENGTH = 1024,
  parameter int MSG_LENGTH_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_nd,
  output logic [WIDTH-1:0]     out_data,
  output logic [N_STREAMS-1:0] out_nd,
  output logic                 error
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  // The limits are one bit wider than the fields they are compared against.
  // That way N_STREAMS and MAX_PACKET_LENGTH always fit, even when they equal 2**field_width.
  localparam logic [LOG_N_STREAMS:0]    N_STREAMS_L = (LOG_N_STREAMS + 1)'(N_STREAMS);
  localparam logic [MSG_LENGTH_WIDTH:0] MAX_LEN_L   = (MSG_LENGTH_WIDTH + 1)'(MAX_PACKET_LENGTH);
  localparam logic [MSG_LENGTH_WIDTH-1:0] ONE_L     = MSG_LENGTH_WIDTH'(1);
  localparam logic [N_STREAMS-1:0]      ND_ONE_L    = N_STREAMS'(1);

  state_e                      state_q, state_d;
  logic [MSG_LENGTH_WIDTH-1:0] remaining_q, remaining_d;
  logic [LOG_N_STREAMS-1:0]    id_q, id_d;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic [N_STREAMS-1:0]        out_nd_q, out_nd_d;
  logic                        error_q, error_d;

  logic [LOG_N_STREAMS-1:0]    hdr_id_s;
  logic [MSG_LENGTH_WIDTH-1:0] hdr_len_s;
  logic                        hdr_ok_s;
  logic                        fwd_s;
  logic [LOG_N_STREAMS-1:0]    fwd_id_s;

  // Header field decode and legality check for the incoming word.
  always_comb begin
    hdr_id_s  = in_data[WIDTH-2 -: LOG_N_STREAMS];
    hdr_len_s = in_data[MSG_LENGTH_WIDTH-1:0];
    hdr_ok_s  = in_data[WIDTH-1]
              && ({1'b0, hdr_id_s} < N_STREAMS_L)
              && ({1'b0, hdr_len_s} <= MAX_LEN_L);
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    id_d        = id_q;
    error_d     = error_q;
    out_data_d  = out_data_q;
    out_nd_d    = '0;
    fwd_s       = 1'b0;
    fwd_id_s    = id_q;

    if (in_nd) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_ok_s) begin
            fwd_s       = 1'b1;
            fwd_id_s    = hdr_id_s;
            id_d        = hdr_id_s;
            remaining_d = hdr_len_s;
            // A zero-length message is complete with its header.
            if (hdr_len_s != '0) begin
              state_d = ST_PAYLOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            error_d = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          // Payload words are forwarded verbatim; their MSB carries no meaning.
          fwd_s       = 1'b1;
          fwd_id_s    = id_q;
          remaining_d = remaining_q - ONE_L;
          if (remaining_q == ONE_L) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (fwd_s) begin
      out_data_d = in_data;
      out_nd_d   = ND_ONE_L << fwd_id_s;
    end else begin
      out_nd_d = '0;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      id_q        <= '0;
      out_data_q  <= '0;
      out_nd_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      id_q        <= id_d;
      out_data_q  <= out_data_d;
      out_nd_q    <= out_nd_d;
      error_q     <= error_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule
